mem_handshake_responder: RTL and testbench
==========================================

// Module: mem_handshake_responder
// PURPOSE
//  Word-organised data memory that answers CPU load/store requests over a req/ack
//  handshake with a programmable number of wait states.
//  Replaces the fixed-latency memory path when the multicycle control unit stalls on ack.
//  Has byte-lane enables for SB/SH stores and an optional bus-error flag that feeds the
//  exception handler.
// PARAMETERS
//  ADDR_W       32   byte-address width
//  DEPTH        256  number of 32-bit words in the array
//  WAIT_STATES  1    extra cycles between acceptance and response (legal range 0..15)
// PORTS
//  clk    in   1       rising-edge clock
//  reset  in   1       asynchronous, active-low reset
//  req    in   1       request valid; held high with addr/we/wdata/be stable until ack
//  we     in   1       1 = store, 0 = load
//  addr   in   ADDR_W  byte address; word index = addr[ADDR_W-1:2]
//  wdata  in   32      store data
//  be     in   4       byte-lane enables; be[i] writes wdata[8i+7:8i]
//  rdata  out  32      load data; valid while ack=1, held until the next response
//  ack    out  1       one-cycle response pulse
//  busy   out  1       high in WAIT and RESP
//  err    out  1       bus error; pulses with ack (MEM_ERR_EN only, otherwise tied 0)
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE, wait counter=0, ack=0, err=0, busy=0, rdata=0.
//    Array contents are not cleared.
//  - Reset asserted mid-transaction abandons it: no ack is produced. A pending write whose
//    RESP edge has not yet occurred is not performed.
//  - FSM IDLE: req=1 at edge E0 latches addr/we/wdata/be.
//    Next state is WAIT with counter=WAIT_STATES-1, or RESP directly if WAIT_STATES=0.
//  - FSM WAIT: counter decrements each edge; at counter=0 the next state is RESP.
//    Inputs are ignored in WAIT.
//  - Array access happens on the edge that enters RESP, using the latched request:
//    - store: write enabled lanes only. be=0000 writes nothing and still acks.
//    - load: rdata <= full word; be is ignored.
//  - FSM RESP: ack=1 for exactly one cycle, then IDLE.
//    Ack is high in the cycle following edge E0+WAIT_STATES (latency WAIT_STATES+1 cycles).
//  - Back-to-back: if req is still high in IDLE after RESP, it is a new request (no merging).
//    Minimum issue interval is WAIT_STATES+2 cycles.
//  - Read-after-write to the same word returns the newly written data; there is no bypass
//    hazard because accesses are serialised.
//  - All outputs are registered; no combinational path from inputs to ack/rdata/err.
// CONFIGURATION
//  MEM_ERR_EN defined:
//    - err=1 with ack when addr[1:0]!=00 (misaligned) or word index >= DEPTH.
//    - An errored access writes nothing and returns rdata=0.
//  MEM_ERR_EN undefined:
//    - err tied 0; addr[1:0] ignored; word index taken modulo DEPTH (wrap-around aliasing).
// TESTING
//  1. Drive reset=0 mid-WAIT, release -> ack/err/busy/rdata=0, FSM IDLE.
//     Next request is then served normally.
//  2. WAIT_STATES=3: store 0xDEADBEEF @0x10 be=1111, then load @0x10 -> rdata=0xDEADBEEF.
//     Check ack high in exactly the 4th cycle after acceptance and low the cycle after.
//  3. Word 0x20 holds 0x11223344; store wdata=0xAABBCCDD be=0010 -> load returns 0x1122CC44.
//     Then be=0000 -> ack pulses, word unchanged.
//  4. Hold req high across 3 loads: exactly 3 ack pulses, spaced WAIT_STATES+2 cycles.
//  5. MEM_ERR_EN on, DEPTH=256: store @0x00000402 -> ack=1, err=1, memory unchanged.
//     Load @0x400 (word 256) -> err=1, rdata=0.
//  6. MEM_ERR_EN off, DEPTH=256: store 0x5A5A5A5A @0x400 -> load @0x000 returns 0x5A5A5A5A.
//     err stays 0 throughout.

Source files
------------

// File: rtl/mem_handshake_responder.sv
// Word-organised data memory with req/ack handshake, programmable wait states and byte lanes.
// Optional bus-error reporting is compiled in with `define MEM_ERR_EN.
module mem_handshake_responder #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [3:0]        be,
    output logic [31:0]       rdata,
    output logic              ack,
    output logic              busy,
    output logic              err
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_be;
    logic [31:0]       r_rdata;
    logic              r_ack;
    logic              r_busy;
    logic              r_err;
    logic [31:0]       r_mem [DEPTH];

    logic              w_acc_we;
    logic [ADDR_W-1:0] w_acc_addr;
    logic [31:0]       w_acc_wdata;
    logic [3:0]        w_acc_be;
    logic [ADDR_W-3:0] w_word;
    logic [IDX_W-1:0]  w_idx;
    logic              w_err;
    logic              w_enter_resp;
    logic              w_wr;

    // With zero wait states the access happens on the accepting edge, so the live inputs are used.
    assign w_acc_we    = (r_state == S_IDLE) ? we    : r_we;
    assign w_acc_addr  = (r_state == S_IDLE) ? addr  : r_addr;
    assign w_acc_wdata = (r_state == S_IDLE) ? wdata : r_wdata;
    assign w_acc_be    = (r_state == S_IDLE) ? be    : r_be;

    assign w_word = w_acc_addr[ADDR_W-1:2];
    assign w_idx  = IDX_W'(w_word % (ADDR_W-2)'(DEPTH));

`ifdef MEM_ERR_EN
    assign w_err = (w_acc_addr[1:0] != 2'b00) || (w_word >= (ADDR_W-2)'(DEPTH));
`else
    logic w_unused_lsb;
    assign w_unused_lsb = ^w_acc_addr[1:0];
    assign w_err        = 1'b0;
`endif

    // Gated with reset so an edge seen while reset is held never performs the access.
    assign w_enter_resp = reset &&
                          (((r_state == S_IDLE) && req && (WAIT_STATES == 0)) ||
                           ((r_state == S_WAIT) && (r_cnt == 4'd0)));
    assign w_wr = w_enter_resp && w_acc_we && !w_err;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (w_acc_be[i]) r_mem[w_idx][8*i +: 8] <= w_acc_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_rdata <= '0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_we    <= we;
                        r_addr  <= addr;
                        r_wdata <= wdata;
                        r_be    <= be;
                        r_busy  <= 1'b1;
                        if (WAIT_STATES == 0) begin
                            r_state <= S_RESP;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= 4'(WAIT_STATES - 1);
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) r_state <= S_RESP;
                    else               r_cnt   <= r_cnt - 4'd1;
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
            if (w_enter_resp) begin
                r_ack <= 1'b1;
                r_err <= w_err;
                if (!w_acc_we) r_rdata <= w_err ? '0 : r_mem[w_idx];
            end
        end
    end

    assign rdata = r_rdata;
    assign ack   = r_ack;
    assign busy  = r_busy;
    assign err   = r_err;

endmodule

// File: tb/tb_mem_handshake_responder.sv
// Directed bench for mem_handshake_responder with WAIT_STATES=3.
// Error-path vectors follow whether MEM_ERR_EN is defined for the build.
module tb_mem_handshake_responder;

    localparam int unsigned WS = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        ack;
    logic        busy;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    mem_handshake_responder #(
        .ADDR_W      (32),
        .DEPTH       (256),
        .WAIT_STATES (WS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .be    (be),
        .rdata (rdata),
        .ack   (ack),
        .busy  (busy),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issues one request and waits for ack; lat counts cycles after the accepting edge.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, output logic [31:0] rd, output logic e,
                        output int lat, output logic ack_after);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ack && lat < 40);
        rd = rdata;
        e  = err;
        req = 1'b0;
        @(negedge clk);
        ack_after = ack;
    endtask

    logic [31:0] rd;
    logic        e;
    logic        ack_after;
    int          lat;
    int          n_acks;
    int          ack_cyc [3];
    logic [31:0] ack_dat [3];

    initial begin
        reset = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
        repeat (2) @(negedge clk);
        check("rst_ack",   32'(ack),  32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_err",   32'(err),  32'd0);
        check("rst_rdata", rdata,     32'd0);
        reset = 1'b1;

        // Reset in the middle of WAIT abandons the pending store.
        xfer(1'b1, 32'h30, 32'h12345678, 4'hF, rd, e, lat, ack_after);
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h30; wdata = 32'hCAFEF00D; be = 4'hF;
        @(negedge clk);
        check("abort_busy_in_wait", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check("abort_busy_async", 32'(busy), 32'd0);
        req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        n_acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ack) n_acks++;
        end
        check("abort_no_ack", 32'(n_acks), 32'd0);
        check("abort_rdata", rdata, 32'd0);
        xfer(1'b0, 32'h30, 32'h0, 4'h0, rd, e, lat, ack_after);
        check("abort_not_written", rd, 32'h12345678);
        check("abort_next_lat", 32'(lat), 32'd4);

        // Full-word store/load and latency of WS+1.
        xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, e, lat, ack_after);
        check("st_lat", 32'(lat), 32'd4);
        check("st_ack_low_after", 32'(ack_after), 32'd0);
        check("st_rdata_held", rd, 32'h12345678);
        xfer(1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat, ack_after);
        check("ld_data", rd, 32'hDEADBEEF);
        check("ld_lat", 32'(lat), 32'd4);
        check("ld_ack_low_after", 32'(ack_after), 32'd0);
        check("ld_err", 32'(e), 32'd0);

        // Byte lanes.
        xfer(1'b1, 32'h20, 32'h11223344, 4'hF, rd, e, lat, ack_after);
        xfer(1'b1, 32'h20, 32'hAABBCCDD, 4'b0010, rd, e, lat, ack_after);
        xfer(1'b0, 32'h20, 32'h0, 4'h0, rd, e, lat, ack_after);
        check("lane1_merge", rd, 32'h1122CC44);
        xfer(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, rd, e, lat, ack_after);
        check("be0_acks", 32'(lat), 32'd4);
        xfer(1'b0, 32'h20, 32'h0, 4'b0000, rd, e, lat, ack_after);
        check("be0_unchanged", rd, 32'h1122CC44);
        xfer(1'b1, 32'h24, 32'h55667788, 4'b1001, rd, e, lat, ack_after);
        xfer(1'b0, 32'h24, 32'h0, 4'h0, rd, e, lat, ack_after);
        check("lane03_merge", rd & 32'hFF0000FF, 32'h55000088);

        // req held high across three loads: three acks spaced WS+2 cycles.
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h10; be = 4'hF;
        n_acks = 0;
        for (int c = 1; c <= 40 && n_acks < 3; c++) begin
            @(negedge clk);
            if (ack) begin
                ack_cyc[n_acks] = c;
                ack_dat[n_acks] = rdata;
                n_acks++;
                addr = (n_acks == 1) ? 32'h20 : 32'h30;
                if (n_acks == 3) req = 1'b0;
            end
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ack) n_acks++;
        end
        check("b2b_count", 32'(n_acks), 32'd3);
        check("b2b_first", 32'(ack_cyc[0]), 32'd4);
        check("b2b_gap1", 32'(ack_cyc[1] - ack_cyc[0]), 32'(WS + 2));
        check("b2b_gap2", 32'(ack_cyc[2] - ack_cyc[1]), 32'(WS + 2));
        check("b2b_d0", ack_dat[0], 32'hDEADBEEF);
        check("b2b_d1", ack_dat[1], 32'h1122CC44);
        check("b2b_d2", ack_dat[2], 32'h12345678);

`ifdef MEM_ERR_EN
        xfer(1'b1, 32'h0, 32'h0BADF00D, 4'hF, rd, e, lat, ack_after);
        check("err_ok_store", 32'(e), 32'd0);
        xfer(1'b1, 32'h402, 32'hFFFFFFFF, 4'hF, rd, e, lat, ack_after);
        check("err_st_lat", 32'(lat), 32'd4);
        check("err_st_flag", 32'(e), 32'd1);
        check("err_low_after", 32'(err), 32'd0);
        xfer(1'b0, 32'h0, 32'h0, 4'h0, rd, e, lat, ack_after);
        check("err_mem_unchanged", rd, 32'h0BADF00D);
        check("err_ok_load", 32'(e), 32'd0);
        xfer(1'b0, 32'h400, 32'h0, 4'h0, rd, e, lat, ack_after);
        check("err_oob_flag", 32'(e), 32'd1);
        check("err_oob_rdata", rd, 32'd0);
        xfer(1'b1, 32'h11, 32'hFFFFFFFF, 4'hF, rd, e, lat, ack_after);
        check("err_misalign_flag", 32'(e), 32'd1);
        xfer(1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat, ack_after);
        check("err_misalign_nowrite", rd, 32'hDEADBEEF);
`else
        xfer(1'b1, 32'h400, 32'h5A5A5A5A, 4'hF, rd, e, lat, ack_after);
        check("wrap_st_err", 32'(e), 32'd0);
        xfer(1'b0, 32'h000, 32'h0, 4'h0, rd, e, lat, ack_after);
        check("wrap_alias", rd, 32'h5A5A5A5A);
        check("wrap_ld_err", 32'(e), 32'd0);
        xfer(1'b1, 32'h13, 32'h01020304, 4'hF, rd, e, lat, ack_after);
        check("lsb_st_err", 32'(e), 32'd0);
        xfer(1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat, ack_after);
        check("lsb_ignored", rd, 32'h01020304);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
